// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
// video_timing_pkg : mode encoding, bar colours, counter-width helper
// Rev 1.0
// ============================================================================
package video_timing_pkg;

  localparam logic [1:0] c_MODE_FB   = 2'd0;
  localparam logic [1:0] c_MODE_BARS = 2'd1;
  localparam logic [1:0] c_MODE_GRID = 2'd2;
  localparam logic [1:0] c_MODE_RAMP = 2'd3;

  localparam logic [23:0] c_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] c_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] c_CYAN    = 24'h00FFFF;
  localparam logic [23:0] c_GREEN   = 24'h00FF00;
  localparam logic [23:0] c_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] c_RED     = 24'hFF0000;
  localparam logic [23:0] c_BLUE    = 24'h0000FF;
  localparam logic [23:0] c_BLACK   = 24'h000000;

  function automatic int f_cnt_w(input int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

  function automatic logic [23:0] f_bar_rgb(input logic [2:0] idx);
    logic [23:0] rgb;
    case (idx)
      3'd0:    rgb = c_WHITE;
      3'd1:    rgb = c_YELLOW;
      3'd2:    rgb = c_CYAN;
      3'd3:    rgb = c_GREEN;
      3'd4:    rgb = c_MAGENTA;
      3'd5:    rgb = c_RED;
      3'd6:    rgb = c_BLUE;
      default: rgb = c_BLACK;
    endcase
    return rgb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_pattern_gen.sv
`default_nettype none
// ============================================================================
// video_pattern_gen : registered colour-bar / grid / ramp pixel from counters
// Rev 1.0
// ============================================================================
module video_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = 1024,
  parameter int H_TOTAL  = 1344,
  parameter int HW       = 11,
  parameter int VW       = 10,
  parameter int DATA_W   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HW-1:0]     i_h_cnt,
  input  logic [VW-1:0]     i_v_cnt,
  input  logic [1:0]        i_mode,
  output logic [DATA_W-1:0] o_pix
);

  localparam int c_BAR_W = H_ACTIVE / 8;
  localparam int c_CH_W  = DATA_W / 3;
  localparam int c_PW    = f_cnt_w(c_BAR_W);
  localparam logic [c_PW-1:0] c_POS_LAST = c_PW'(c_BAR_W - 1);
  localparam logic [HW-1:0]   c_H_LAST   = HW'(H_TOTAL - 1);

  logic [c_PW-1:0]   r_bar_pos;
  logic [2:0]        r_bar_idx;
  logic [DATA_W-1:0] r_pix;
  logic [4:0]        w_h5;
  logic [4:0]        w_v5;
  logic [7:0]        w_h8;
  logic [c_CH_W-1:0] w_ramp;
  logic [DATA_W-1:0] w_pix;

  // Bar index tracks h_cnt with a position counter so no divider is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bar_pos <= '0;
      r_bar_idx <= '0;
    end else if (i_h_cnt == c_H_LAST) begin
      r_bar_pos <= '0;
      r_bar_idx <= '0;
    end else if (r_bar_pos == c_POS_LAST) begin
      r_bar_pos <= '0;
      r_bar_idx <= (r_bar_idx == 3'd7) ? 3'd7 : r_bar_idx + 3'd1;
    end else begin
      r_bar_pos <= r_bar_pos + 1'b1;
    end
  end

  always_comb begin
    w_h5   = 5'(i_h_cnt);
    w_v5   = 5'(i_v_cnt);
    w_h8   = 8'(i_h_cnt);
    // MSB-align the 8-bit ramp into a channel of any width.
    w_ramp = c_CH_W'({w_h8, {c_CH_W{1'b0}}} >> 8);
    w_pix  = '0;
    case (i_mode)
      c_MODE_BARS: w_pix = DATA_W'(f_bar_rgb(r_bar_idx));
      c_MODE_GRID: w_pix = ((w_h5 == 5'd0) || (w_v5 == 5'd0)) ? '1 : '0;
      c_MODE_RAMP: w_pix = {3{w_ramp}};
      default:     w_pix = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pix <= '0;
    else     r_pix <= w_pix;
  end

  assign o_pix = r_pix;

endmodule
`default_nettype wire

// File: rtl/video_timing_ctrl.sv
`default_nettype none
// ============================================================================
// video_timing_ctrl : sync generation, frame read request, latency-matched pixels
// Rev 1.0
// ============================================================================
module video_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int DATA_W   = 24,
  parameter int RD_LAT   = 1
) (
  input  logic              video_clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  output logic              read_req,
  input  logic              read_req_ack,
  output logic              read_en,
  input  logic [DATA_W-1:0] read_data,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic [DATA_W-1:0] vout_data,
  output logic              frame_err
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_HW      = f_cnt_w(c_H_TOTAL);
  localparam int c_VW      = f_cnt_w(c_V_TOTAL);
  localparam int c_DLY_W   = DATA_W + 4;
  localparam logic [c_HW-1:0] c_H_LAST  = c_HW'(c_H_TOTAL - 1);
  localparam logic [c_HW-1:0] c_H_ACT   = c_HW'(H_ACTIVE);
  localparam logic [c_HW-1:0] c_HS_BEG  = c_HW'(H_ACTIVE + H_FP);
  localparam logic [c_HW-1:0] c_HS_END  = c_HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [c_VW-1:0] c_V_LAST  = c_VW'(c_V_TOTAL - 1);
  localparam logic [c_VW-1:0] c_V_ACT   = c_VW'(V_ACTIVE);
  localparam logic [c_VW-1:0] c_VS_BEG  = c_VW'(V_ACTIVE + V_FP);
  localparam logic [c_VW-1:0] c_VS_END  = c_VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [c_HW-1:0]    r_h_cnt;
  logic [c_VW-1:0]    r_v_cnt;
  logic [1:0]         r_active_mode;
  logic [1:0]         w_mode_next;
  logic               w_sof, w_req_line, w_raw_de, w_raw_hs, w_raw_vs, w_fb;
  logic               r_hs0, r_vs0, r_de0, r_fb0;
  logic               r_read_en, r_read_req, r_frame_err;
  logic [DATA_W-1:0]  w_pix;
  logic [c_DLY_W-1:0] r_dly [RD_LAT];
  logic               w_t_hs, w_t_vs, w_t_de, w_t_fb;
  logic [DATA_W-1:0]  w_t_pix;
  logic               r_hs, r_vs, r_de;
  logic [DATA_W-1:0]  r_vout;

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == c_H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  // The mode used at frame start is the one everything in stage 0 sees.
  always_comb begin
    w_sof       = (r_h_cnt == '0) && (r_v_cnt == '0);
    w_req_line  = (r_h_cnt == '0) && (r_v_cnt == c_VS_BEG);
    w_raw_de    = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
    w_raw_hs    = (r_h_cnt >= c_HS_BEG) && (r_h_cnt < c_HS_END);
    w_raw_vs    = (r_v_cnt >= c_VS_BEG) && (r_v_cnt < c_VS_END);
    w_mode_next = r_active_mode;
    if (w_sof) w_mode_next = r_read_req ? c_MODE_BARS : mode;
    w_fb        = (w_mode_next == c_MODE_FB);
  end

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      r_hs0         <= 1'b0;
      r_vs0         <= 1'b0;
      r_de0         <= 1'b0;
      r_fb0         <= 1'b0;
      r_read_en     <= 1'b0;
      r_active_mode <= c_MODE_FB;
      r_read_req    <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_hs0         <= w_raw_hs;
      r_vs0         <= w_raw_vs;
      r_de0         <= w_raw_de;
      r_fb0         <= w_fb;
      r_read_en     <= w_raw_de && w_fb;
      r_active_mode <= w_mode_next;
      r_frame_err   <= w_sof && r_read_req;
      if (r_read_req && read_req_ack) r_read_req <= 1'b0;
      else if (w_req_line)            r_read_req <= 1'b1;
    end
  end

  video_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_TOTAL  (c_H_TOTAL),
    .HW       (c_HW),
    .VW       (c_VW),
    .DATA_W   (DATA_W)
  ) u_pattern (
    .clk     (video_clk),
    .rst     (rst),
    .i_h_cnt (r_h_cnt),
    .i_v_cnt (r_v_cnt),
    .i_mode  (w_mode_next),
    .o_pix   (w_pix)
  );

  // Syncs travel as active-high flags so a cleared delay line means idle.
  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) r_dly[i] <= '0;
    end else begin
      r_dly[0] <= {r_hs0, r_vs0, r_de0, r_fb0, w_pix};
      for (int i = 1; i < RD_LAT; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  assign {w_t_hs, w_t_vs, w_t_de, w_t_fb, w_t_pix} = r_dly[RD_LAT-1];

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      r_hs   <= ~HS_POL;
      r_vs   <= ~VS_POL;
      r_de   <= 1'b0;
      r_vout <= '0;
    end else begin
      r_hs   <= w_t_hs ? HS_POL : ~HS_POL;
      r_vs   <= w_t_vs ? VS_POL : ~VS_POL;
      r_de   <= w_t_de;
      r_vout <= !w_t_de ? '0 : (w_t_fb ? read_data : w_t_pix);
    end
  end

  assign read_req  = r_read_req;
  assign read_en   = r_read_en;
  assign frame_err = r_frame_err;
  assign hs        = r_hs;
  assign vs        = r_vs;
  assign de        = r_de;
  assign vout_data = r_vout;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_ctrl.sv
`default_nettype none
// ============================================================================
// tb_video_timing_ctrl : directed bench on a 24x8 raster with RD_LAT = 2
// Rev 1.0
// ============================================================================
module tb_video_timing_ctrl;

  localparam logic [23:0] c_BASE = 24'h5A0000;

  logic        video_clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic        read_req_ack = 1'b0;
  logic [23:0] read_data;
  logic        read_req, read_en, hs, vs, de, frame_err;
  logic [23:0] vout_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] fm [8];
  int noack_frame;
  int run_id;

  logic [23:0] r_p0, r_p1;
  int          rd_idx;

  always #5 video_clk = ~video_clk;

  video_timing_ctrl #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (4),  .V_FP (1), .V_SYNC (2), .V_BP (1),
    .HS_POL (1'b0), .VS_POL (1'b0), .DATA_W (24), .RD_LAT (2)
  ) dut (
    .video_clk    (video_clk),
    .rst          (rst),
    .mode         (mode),
    .read_req     (read_req),
    .read_req_ack (read_req_ack),
    .read_en      (read_en),
    .read_data    (read_data),
    .hs           (hs),
    .vs           (vs),
    .de           (de),
    .vout_data    (vout_data),
    .frame_err    (frame_err)
  );

  // Frame-buffer model: pixel value = base + read index, valid two cycles after read_en.
  always @(posedge video_clk) begin
    if (rst) begin
      r_p0   <= '0;
      r_p1   <= '0;
      rd_idx <= 0;
    end else begin
      if (read_en) begin
        r_p0   <= c_BASE + 24'(rd_idx);
        rd_idx <= rd_idx + 1;
      end
      r_p1 <= r_p0;
    end
  end
  assign read_data = r_p1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [23:0] bar_rgb(input int h);
    int b;
    b = h / 2;
    if (b > 7) b = 7;
    case (b)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // k = index of the rising edge after reset release (first edge is 0).
  task automatic run(input int kmax);
    logic        exp_req;
    int          fb_cnt, n, h, v;
    logic        ed;
    logic [23:0] evd;
    logic [7:0]  h8;
    exp_req = 1'b0;
    fb_cnt  = 0;
    for (int k = 0; k <= kmax; k++) begin
      @(posedge video_clk);
      if (exp_req && read_req_ack) exp_req = 1'b0;
      else if (k % 192 == 120)     exp_req = 1'b1;
      @(negedge video_clk);

      h = k % 24;
      v = (k / 24) % 8;
      check("read_en", read_en, (h < 16 && v < 4 && fm[k/192] == 2'd0));

      if (k < 3) begin
        check("hs_idle", hs, 1);
        check("vs_idle", vs, 1);
        check("de_idle", de, 0);
        check("vout_idle", vout_data, 0);
      end else begin
        n  = k - 3;
        h  = n % 24;
        v  = (n / 24) % 8;
        ed = (h < 16) && (v < 4);
        check("hs", hs, !(h >= 18 && h < 21));
        check("vs", vs, !(v >= 5 && v < 7));
        check("de", de, ed);
        evd = '0;
        if (ed) begin
          h8 = 8'(h);
          case (fm[n/192])
            2'd0: begin evd = c_BASE + 24'(fb_cnt); fb_cnt++; end
            2'd1: evd = bar_rgb(h);
            2'd2: evd = (h == 0 || v == 0) ? 24'hFFFFFF : 24'h000000;
            default: evd = {h8, h8, h8};
          endcase
        end
        check("vout", vout_data, evd);
      end

      check("frame_err", frame_err, (noack_frame >= 0 && k == (noack_frame + 1) * 192));
      check("read_req", read_req, exp_req);

      if (k % 192 == 50) read_req_ack = 1'b1;
      if (k % 192 == 51) read_req_ack = 1'b0;
      if (k / 192 != noack_frame) begin
        if (k % 192 == 124) read_req_ack = 1'b1;
        if (k % 192 == 125) read_req_ack = 1'b0;
      end
      if (run_id == 1) begin
        if (k == 624)  mode = 2'd1;
        if (k == 868)  mode = 2'd2;
        if (k == 1060) mode = 2'd3;
      end
    end
  endtask

  task automatic check_reset_state();
    check("rst_hs", hs, 1);
    check("rst_vs", vs, 1);
    check("rst_de", de, 0);
    check("rst_vout", vout_data, 0);
    check("rst_read_req", read_req, 0);
    check("rst_read_en", read_en, 0);
    check("rst_frame_err", frame_err, 0);
  endtask

  initial begin
    fm = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    repeat (3) @(posedge video_clk);
    @(negedge video_clk);
    check_reset_state();

    noack_frame = 1;
    run_id      = 1;
    rst         = 1'b0;
    run(1346);

    // Asynchronous reset in the middle of a line, checked before any edge.
    #2;
    rst = 1'b1;
    #1;
    check_reset_state();
    mode         = 2'd0;
    read_req_ack = 1'b0;
    repeat (2) @(posedge video_clk);
    @(negedge video_clk);
    foreach (fm[i]) fm[i] = 2'd0;
    noack_frame = -1;
    run_id      = 2;
    rst         = 1'b0;
    run(220);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
